// File: rtl/gol_pkg.sv
// Shared types and helpers for the Conway engine: sequencer states, bank geometry
// and the (row phase, column phase) -> bank mapping.
package gol_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        SWAP  = 2'd3
    } state_t;

    localparam int PIXELS_PER_BLOCK = 3;
    localparam int NUM_BANKS        = 9;

    function automatic logic [3:0] bank_index(input logic [1:0] row_phase,
                                              input logic [1:0] col_phase);
        return (4'(row_phase) * 4'd3) + 4'(col_phase);
    endfunction

endpackage

// File: rtl/gen_sequencer_wrap_coord.sv
// One torus coordinate held as a (block, phase) pair, with wrapped previous and
// next neighbours so no divider or modulo logic is needed.
module wrap_coord
    import gol_pkg::*;
#(
    parameter int BLOCKS = 2,
    localparam int BW    = (BLOCKS > 1) ? $clog2(BLOCKS) : 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          clear,
    input  logic          advance,
    output logic [BW-1:0] block,
    output logic [1:0]    phase,
    output logic [BW-1:0] prev_block,
    output logic [1:0]    prev_phase,
    output logic [BW-1:0] next_block,
    output logic [1:0]    next_phase,
    output logic          last
);

    localparam logic [BW-1:0] LAST_BLOCK = BW'(BLOCKS - 1);
    localparam logic [1:0]    LAST_PHASE = 2'(PIXELS_PER_BLOCK - 1);

    assign last = (block == LAST_BLOCK) && (phase == LAST_PHASE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            block <= '0;
            phase <= '0;
        end else if (clear) begin
            block <= '0;
            phase <= '0;
        end else if (advance) begin
            if (last) begin
                block <= '0;
                phase <= '0;
            end else if (phase == LAST_PHASE) begin
                block <= block + BW'(1);
                phase <= '0;
            end else begin
                phase <= phase + 2'd1;
            end
        end
    end

    always_comb begin
        prev_block = block;
        prev_phase = phase - 2'd1;
        next_block = block;
        next_phase = phase + 2'd1;
        // Stepping across a block boundary borrows/carries into the block count.
        if (phase == 2'd0) begin
            prev_phase = LAST_PHASE;
            prev_block = (block == '0) ? LAST_BLOCK : block - BW'(1);
        end
        if (phase == LAST_PHASE) begin
            next_phase = 2'd0;
            next_block = (block == LAST_BLOCK) ? '0 : block + BW'(1);
        end
    end

endmodule

// File: rtl/gen_sequencer.sv
// Generation sequencer: raster-scans the torus, issues 3x3 reads to nine banks,
// writes each centre cell one cycle later and swaps buffers at the end.
module gen_sequencer
    import gol_pkg::*;
#(
    parameter int ADDR_WIDTH    = 2,
    parameter int WIDTH_PIXELS  = 6,
    parameter int HEIGHT_PIXELS = 6,
    parameter int WIDTH_BLOCKS  = 2,
    parameter int HEIGHT_BLOCKS = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  frame_buffer_select,
    output logic [8:0]            read_enable,
    output logic [ADDR_WIDTH-1:0] read_addr_0,
    output logic [ADDR_WIDTH-1:0] read_addr_1,
    output logic [ADDR_WIDTH-1:0] read_addr_2,
    output logic [ADDR_WIDTH-1:0] read_addr_3,
    output logic [ADDR_WIDTH-1:0] read_addr_4,
    output logic [ADDR_WIDTH-1:0] read_addr_5,
    output logic [ADDR_WIDTH-1:0] read_addr_6,
    output logic [ADDR_WIDTH-1:0] read_addr_7,
    output logic [ADDR_WIDTH-1:0] read_addr_8,
    output logic [8:0]            write_enable,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output state_t                state
);

    localparam int XBW = (WIDTH_BLOCKS > 1) ? $clog2(WIDTH_BLOCKS) : 1;
    localparam int YBW = (HEIGHT_BLOCKS > 1) ? $clog2(HEIGHT_BLOCKS) : 1;

    state_t state_q, state_d;
    logic   in_run, cell_last;

    logic [XBW-1:0] col_blk [3];
    logic [1:0]     col_ph  [3];
    logic [YBW-1:0] row_blk [3];
    logic [1:0]     row_ph  [3];
    logic           x_last, y_last;

    logic [ADDR_WIDTH-1:0] rd_addr [NUM_BANKS];
    logic                  wr_valid;
    logic [8:0]            wr_bank;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  fbs;

    assign in_run    = (state_q == RUN);
    assign cell_last = x_last && y_last;

    wrap_coord #(.BLOCKS(WIDTH_BLOCKS)) u_x (
        .clk(clk), .resetn(resetn), .clear(state_q == IDLE), .advance(in_run),
        .block(col_blk[1]), .phase(col_ph[1]),
        .prev_block(col_blk[0]), .prev_phase(col_ph[0]),
        .next_block(col_blk[2]), .next_phase(col_ph[2]),
        .last(x_last)
    );

    wrap_coord #(.BLOCKS(HEIGHT_BLOCKS)) u_y (
        .clk(clk), .resetn(resetn), .clear(state_q == IDLE), .advance(in_run && x_last),
        .block(row_blk[1]), .phase(row_ph[1]),
        .prev_block(row_blk[0]), .prev_phase(row_ph[0]),
        .next_block(row_blk[2]), .next_phase(row_ph[2]),
        .last(y_last)
    );

    function automatic logic [ADDR_WIDTH-1:0] word_of(input logic [YBW-1:0] rb,
                                                      input logic [XBW-1:0] cb);
        return ADDR_WIDTH'(int'(rb) * WIDTH_BLOCKS + int'(cb));
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cell_last) state_d = DRAIN;
            DRAIN:   state_d = SWAP;
            SWAP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != IDLE);
        done        = (state_q == SWAP);
        read_enable = in_run ? 9'h1FF : 9'h000;
    end

    // Each window cell lands in a distinct bank, so every bank gets exactly one address.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) rd_addr[b] = '0;
        if (in_run) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    rd_addr[bank_index(row_ph[r], col_ph[c])] = word_of(row_blk[r], col_blk[c]);
                end
            end
        end
    end

    assign read_addr_0 = rd_addr[0];
    assign read_addr_1 = rd_addr[1];
    assign read_addr_2 = rd_addr[2];
    assign read_addr_3 = rd_addr[3];
    assign read_addr_4 = rd_addr[4];
    assign read_addr_5 = rd_addr[5];
    assign read_addr_6 = rd_addr[6];
    assign read_addr_7 = rd_addr[7];
    assign read_addr_8 = rd_addr[8];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_valid <= 1'b0;
            wr_bank  <= '0;
            wr_addr  <= '0;
        end else begin
            wr_valid <= in_run;
            if (in_run) begin
                wr_bank <= 9'b1 << bank_index(row_ph[1], col_ph[1]);
                wr_addr <= word_of(row_blk[1], col_blk[1]);
            end
        end
    end

    assign write_enable = wr_valid ? wr_bank : 9'h000;
    assign write_addr   = wr_addr;

    // Flip on leaving DRAIN so the new buffer is already visible alongside done.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)              fbs <= 1'b0;
        else if (state_q == DRAIN) fbs <= ~fbs;
    end

    assign frame_buffer_select = fbs;
    assign state               = state_q;

endmodule

// File: doc/gen_sequencer.md
# gen_sequencer

Generation sequencer for the Conway engine: walks every cell of the WIDTH_PIXELS x HEIGHT_PIXELS torus once per generation and drives the nine-bank, double-buffered frame-buffer data path. Each cycle it issues a 3x3 neighbourhood read to all nine banks, then one cycle later a write strobe for the centre cell into the opposite buffer. After the last write it swaps buffers. It sits between the top-level control (start/done) and the data path's address/enable ports.

## Interface
- ADDR_WIDTH, 2: word address width per bank.
- WIDTH_PIXELS, 6: grid width; multiple of 3.
- HEIGHT_PIXELS, 6: grid height; multiple of 3.
- WIDTH_BLOCKS, 2: WIDTH_PIXELS/3.
- HEIGHT_BLOCKS, 2: HEIGHT_PIXELS/3.

Ports:
- clk  in  1  single clock; everything is on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request one generation; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when a generation is complete.
- frame_buffer_select  out  1  selects the read/write buffer pair; toggles once per generation.
- read_enable  out  9  per-bank read strobe.
- read_addr_0 .. read_addr_8  out  ADDR_WIDTH each  per-bank read word address.
- write_enable  out  9  one-hot bank write strobe.
- write_addr  out  ADDR_WIDTH  shared write word address.

## Operation
- **Cell mapping.** Cell (x,y) lives in bank (y mod 3)*3 + (x mod 3), at word (y/3)*WIDTH_BLOCKS + (x/3).
  - Coordinates are held as (block, phase) counter pairs. No divider or modulo hardware is used.
  - Any 3x3 window touches every bank exactly once.
- **Neighbourhood.** The window for (x,y) is x-1..x+1 by y-1..y+1 with toroidal wrap.
  - x-1 at x=0 is WIDTH_PIXELS-1; x+1 at WIDTH_PIXELS-1 is 0. The same rules apply to y.
  - read_addr_b is the word address of the window cell that maps to bank b.
- **Scan order.** Raster: x fastest, then y. N = WIDTH_PIXELS*HEIGHT_PIXELS cells.
- **States.**
  - IDLE: outputs quiet. If start=1, go to RUN with the cell counter at (0,0).
  - RUN: read_enable=9'h1FF with the current cell's addresses, then advance one cell. After cell N-1 is issued, go to DRAIN.
  - DRAIN: read_enable=0; the last write occurs. Go to SWAP.
  - SWAP: frame_buffer_select toggles and done=1. Go to IDLE.
- **Write stage.** This is a one-deep pipeline register loaded in every RUN cycle with the centre bank one-hot and the centre word.
  - The next cycle presents it on write_enable/write_addr.
  - write_enable is 0 whenever the register is not valid.
- **Other rules.**
  - start while busy is ignored.
  - frame_buffer_select is held constant for the whole of RUN and DRAIN.

## Timing
- Reset values: state IDLE; busy=0, done=0, frame_buffer_select=0; read_enable=0, write_enable=0; all addresses 0; pipeline register invalid.
- Cycle schedule, with start sampled high in IDLE at edge 0:
  - RUN reads cell k at cycle 1+k, for k=0..N-1.
  - The write for cell k occurs at cycle 2+k.
  - DRAIN is cycle N+1; the write for cell N-1 occurs there.
  - SWAP is cycle N+2: done=1 and frame_buffer_select flips.
  - busy=1 for cycles 1..N+2.
  - Total generation latency is N+2 cycles from start to done.
- Bank read latency is assumed to be 1 cycle: data for the cycle-t read is valid in cycle t+1, aligned with that cell's write strobe.
- Back-to-back generations: start held high during SWAP is not accepted. The next acceptance is at the first IDLE cycle, so the minimum spacing is N+3 cycles.
- Reset mid-operation: immediately return to IDLE and drop all strobes.
  - frame_buffer_select returns to 0.
  - The partially written buffer is undefined.

## Structure
- Shared package, gol_pkg:
  - state enum {IDLE, RUN, DRAIN, SWAP};
  - constant PIXELS_PER_BLOCK=3;
  - constant NUM_BANKS=9;
  - bank_index(row_phase, col_phase) function.
- Sub-module wrap_coord: one (block, phase) coordinate with wrapping prev/next outputs. It is instantiated twice, once for x and once for y.

## Test plan
- Reset, then idle 10 cycles -> all outputs 0, busy=0, frame_buffer_select=0.
- 6x6 grid, start pulse at edge 0, cycle 1 (cell (0,0)) -> read_addr_0..8 = 0,0,1,0,0,1,2,2,3; write_enable=0.
- 6x6 grid, cycle 2 -> write_enable=9'h001, write_addr=0; cycle 5 (cell (3,0) written) -> write_enable=9'h001, write_addr=1.
- 6x6 full run -> exactly 36 write strobes, each (bank, word) written once; done at cycle 38; frame_buffer_select=1; a second run returns it to 0.
- start held high continuously -> done pulses spaced exactly 39 cycles apart; no extra writes while busy.
- resetn low at cycle 20 of a run -> strobes drop asynchronously; after release the block is in IDLE, frame_buffer_select=0, and a fresh start completes normally.
